halt_ctrl: RTL and testbench
============================

HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of halted-cycle counter (min 4).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 system  in  1  SYSTEM instruction (ECALL/EBREAK) in execute.
REQ-005 misaligned_pc  in  1  fetch PC not 4-byte aligned.
REQ-006 mem_en  in  1  load/store active this cycle.
REQ-007 misaligned_addr  in  1  load/store address misaligned; qualified by mem_en.
REQ-008 dbg_halt_req  in  1  debug host halt request, level.
REQ-009 dbg_resume_req  in  1  debug host resume request, level, held until dbg_resume_ack.
REQ-010 dbg_resume_ack  out  1  one-cycle resume acknowledge pulse.
REQ-011 dbg_step  in  1  start single-step burst (feature-gated, REQ-031).
REQ-012 step_count  in  8  instructions per step burst, sampled with dbg_step.
REQ-013 run_en  out  1  core may retire an instruction this cycle.
REQ-014 halted  out  1  core halted.
REQ-015 halt_cause  out  3  0 none, 1 misaligned_pc, 2 misaligned_addr, 3 system, 4 debug, 5 step.
REQ-016 halt_cycles  out  CNT_W  cycles spent in HALTED since last entry.

Function
REQ-017 FSM states: RUN, HALTED, RESUME, STEP; encoding free.
REQ-018 Halt source hs = system | misaligned_pc | (mem_en & misaligned_addr) | dbg_halt_req.
REQ-019 RUN: run_en=1, halted=0; hs=1 -> HALTED next cycle; halt_cause latched same edge.
REQ-020 Cause priority when several sources coincide: misaligned_pc > misaligned_addr > system > debug.
REQ-021 HALTED: run_en=0, halted=1; halt sources ignored; halt_cause held.
REQ-022 HALTED: halt_cycles loads 0 on entry edge, then +1 per cycle, saturating at all-ones.
REQ-023 HALTED with dbg_resume_req=1 -> RESUME next cycle; resume beats dbg_step in same cycle.
REQ-024 RESUME: exactly one cycle; dbg_resume_ack=1, run_en=0, halted=1; -> RUN; halt_cause cleared to 0 on exit edge; halt_cycles held.
REQ-025 dbg_resume_req in RUN or STEP ignored; no ack generated.
REQ-026 Latency: source asserted cycle N -> halted=1 cycle N+1; resume_req cycle M in HALTED -> ack cycle M+1, run_en=1 cycle M+2.
REQ-027 All outputs registered or decoded from state registers only; no combinational input-to-output path.

Reset
REQ-028 reset_n=0 asynchronously forces RUN, halted=0, run_en=1, dbg_resume_ack=0, halt_cause=0, halt_cycles=0, step counter=0.
REQ-029 Reset asserted in any state, including mid-step or mid-RESUME, abandons operation; no ack emitted after release.
REQ-030 First edge after reset_n deassertion evaluates REQ-019 normally.

Configuration
REQ-031 Macro HALT_CTRL_STEP_EN defined: STEP state and step counter present, as REQ-032..034.
REQ-032 HALTED with dbg_step=1, dbg_resume_req=0, step_count!=0 -> STEP; counter loads step_count; step_count=0 ignored.
REQ-033 STEP: run_en=1, halted=0; counter decrements each cycle; at counter=1 -> HALTED, halt_cause=5.
REQ-034 STEP with hs=1 -> HALTED with source cause (REQ-020), overriding step completion in same cycle.
REQ-035 Macro undefined: dbg_step and step_count ignored, STEP unreachable, cause 5 never produced; ports remain present.

Verification
REQ-036 Reset, pulse misaligned_pc one cycle -> cycle+1 halted=1, run_en=0, halt_cause=1; halt_cycles counts 0,1,2...
REQ-037 mem_en=0 with misaligned_addr=1 -> no halt; same cycle system=1 and mem_en=1,misaligned_addr=1 -> halt_cause=2.
REQ-038 Halted 5 cycles, raise dbg_resume_req -> ack one cycle, halt_cycles frozen at final value, run_en=1 next, halt_cause=0.
REQ-039 CNT_W=4, hold HALTED 40 cycles -> halt_cycles saturates at 15.
REQ-040 STEP_EN: step_count=3, dbg_step -> run_en=1 exactly 3 cycles, then halted, halt_cause=5; system=1 on step 2 -> halt_cause=3.
REQ-041 reset_n low during STEP and during RESUME -> immediate RUN state values per REQ-028, no ack pulse.

Source files
------------

// File: rtl/halt_ctrl_if.sv
// Halt/debug handshake bundle between the core/debug host (master) and halt_ctrl (slave).
interface halt_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             system;
  logic             misaligned_pc;
  logic             mem_en;
  logic             misaligned_addr;
  logic             dbg_halt_req;
  logic             dbg_resume_req;
  logic             dbg_resume_ack;
  logic             dbg_step;
  logic [7:0]       step_count;
  logic             run_en;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] halt_cycles;

  modport master (
    output system, misaligned_pc, mem_en, misaligned_addr,
           dbg_halt_req, dbg_resume_req, dbg_step, step_count,
    input  dbg_resume_ack, run_en, halted, halt_cause, halt_cycles
  );

  modport slave (
    input  system, misaligned_pc, mem_en, misaligned_addr,
           dbg_halt_req, dbg_resume_req, dbg_step, step_count,
    output dbg_resume_ack, run_en, halted, halt_cause, halt_cycles
  );
endinterface

// File: rtl/halt_ctrl.sv
// Core halt controller: RUN/HALTED/RESUME FSM with halt cause and halted-cycle counter.
// Optional single-step burst support is enabled by defining HALT_CTRL_STEP_EN.
module halt_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  halt_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_RESUME = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_PC    = 3'd1;
  localparam logic [2:0] CAUSE_ADDR  = 3'd2;
  localparam logic [2:0] CAUSE_SYS   = 3'd3;
  localparam logic [2:0] CAUSE_DEBUG = 3'd4;
`ifdef HALT_CTRL_STEP_EN
  localparam logic [2:0] CAUSE_STEP  = 3'd5;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             hs;
  logic [2:0]       src_cause;

`ifdef HALT_CTRL_STEP_EN
  logic [7:0]       step_q, step_d;
`else
  logic             unused_step;
  assign unused_step = ^{bus.dbg_step, bus.step_count};
`endif

  // Source decode with fixed priority; src_cause is non-zero exactly when hs is set.
  always_comb begin
    src_cause = CAUSE_NONE;
    if (bus.misaligned_pc)                      src_cause = CAUSE_PC;
    else if (bus.mem_en && bus.misaligned_addr) src_cause = CAUSE_ADDR;
    else if (bus.system)                        src_cause = CAUSE_SYS;
    else if (bus.dbg_halt_req)                  src_cause = CAUSE_DEBUG;
    hs = (src_cause != CAUSE_NONE);
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cycles_d = cycles_q;
`ifdef HALT_CTRL_STEP_EN
    step_d   = step_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (hs) begin
          state_d  = ST_HALTED;
          cause_d  = src_cause;
          cycles_d = '0;
        end
      end
      ST_HALTED: begin
        // The exit edge still counts, so RESUME shows the full number of halted cycles.
        if (!(&cycles_q)) cycles_d = cycles_q + CNT_ONE;
        if (bus.dbg_resume_req) begin
          state_d = ST_RESUME;
        end
`ifdef HALT_CTRL_STEP_EN
        else if (bus.dbg_step && (bus.step_count != 8'd0)) begin
          state_d = ST_STEP;
          step_d  = bus.step_count;
        end
`endif
      end
      ST_RESUME: begin
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
      ST_STEP: begin
`ifdef HALT_CTRL_STEP_EN
        step_d = step_q - 8'd1;
        if (hs) begin
          state_d  = ST_HALTED;
          cause_d  = src_cause;
          cycles_d = '0;
          step_d   = '0;
        end else if (step_q == 8'd1) begin
          state_d  = ST_HALTED;
          cause_d  = CAUSE_STEP;
          cycles_d = '0;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      cause_q  <= CAUSE_NONE;
      cycles_q <= '0;
`ifdef HALT_CTRL_STEP_EN
      step_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cycles_q <= cycles_d;
`ifdef HALT_CTRL_STEP_EN
      step_q   <= step_d;
`endif
    end
  end

  // Outputs decode only registered state, never inputs.
  assign bus.run_en         = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign bus.halted         = (state_q == ST_HALTED) || (state_q == ST_RESUME);
  assign bus.dbg_resume_ack = (state_q == ST_RESUME);
  assign bus.halt_cause     = cause_q;
  assign bus.halt_cycles    = cycles_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: scenario tasks with random parameters, expectations
// computed from cause priority and cycle arithmetic.
module tb_halt_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  halt_ctrl_if #(.CNT_W(16)) hif ();
  halt_ctrl_if #(.CNT_W(4))  sif ();

  halt_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(hif.slave));
  halt_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(sif.slave));

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_cause(input logic pc, input logic addr, input logic mem,
                                           input logic sys, input logic dbg);
    if (pc)               return 3'd1;
    else if (mem && addr) return 3'd2;
    else if (sys)         return 3'd3;
    else if (dbg)         return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [5:0] ev(input logic r, input logic h, input logic a, input logic [2:0] c);
    return {r, h, a, c};
  endfunction

  function automatic logic [5:0] obs16();
    return {hif.run_en, hif.halted, hif.dbg_resume_ack, hif.halt_cause};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hif.system = 0; hif.misaligned_pc = 0; hif.mem_en = 0; hif.misaligned_addr = 0;
    hif.dbg_halt_req = 0; hif.dbg_resume_req = 0; hif.dbg_step = 0; hif.step_count = 8'd0;
    sif.system = 0; sif.misaligned_pc = 0; sif.mem_en = 0; sif.misaligned_addr = 0;
    sif.dbg_halt_req = 0; sif.dbg_resume_req = 0; sif.dbg_step = 0; sif.step_count = 8'd0;
  endtask

  task automatic set_noise();
    hif.system          = 1'($urandom);
    hif.misaligned_pc   = 1'($urandom);
    hif.mem_en          = 1'($urandom);
    hif.misaligned_addr = 1'($urandom);
    hif.dbg_halt_req    = 1'($urandom);
  endtask

  // Issues a resume during the current HALTED cycle; cnt is the halted-cycle total expected.
  task automatic do_resume(input logic [2:0] cause, input int cnt, input string tag);
    hif.dbg_resume_req = 1;
    tick();
    total++;
    if (obs16() !== ev(0, 1, 1, cause)) begin
      bad++; $display("FAIL %s_ack: got %b want %b", tag, obs16(), ev(0, 1, 1, cause));
    end
    total++;
    if (hif.halt_cycles !== 16'(cnt)) begin
      bad++; $display("FAIL %s_cnt_frozen: got %0d want %0d", tag, hif.halt_cycles, cnt);
    end
    idle_inputs();
    tick();
    total++;
    if (obs16() !== ev(1, 0, 0, 3'd0)) begin
      bad++; $display("FAIL %s_run: got %b want %b", tag, obs16(), ev(1, 0, 0, 3'd0));
    end
    total++;
    if (hif.halt_cycles !== 16'(cnt)) begin
      bad++; $display("FAIL %s_cnt_held: got %0d want %0d", tag, hif.halt_cycles, cnt);
    end
    exp_cnt = cnt;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(1, 0, 0, 3'd0), 16'd0}) begin
      bad++; $display("FAIL reset16: got %b want %b", {obs16(), hif.halt_cycles}, {ev(1, 0, 0, 3'd0), 16'd0});
    end
    total++;
    if ({sif.run_en, sif.halted, sif.dbg_resume_ack, sif.halt_cause, sif.halt_cycles} !== 10'b1000000000) begin
      bad++; $display("FAIL reset4: got %b want %b",
        {sif.run_en, sif.halted, sif.dbg_resume_ack, sif.halt_cause, sif.halt_cycles}, 10'b1000000000);
    end
    exp_cnt = 0;
  endtask

  task automatic test_first_edge();
    reset_n = 1;
    hif.misaligned_pc = 1;
    tick();
    hif.misaligned_pc = 0;
    total++;
    if (obs16() !== ev(0, 1, 0, 3'd1)) begin
      bad++; $display("FAIL pc_halt: got %b want %b", obs16(), ev(0, 1, 0, 3'd1));
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (hif.halt_cycles !== 16'(k)) begin
        bad++; $display("FAIL pc_count%0d: got %0d want %0d", k, hif.halt_cycles, k);
      end
      if (k < 4) tick();
    end
    do_resume(3'd1, 5, "pc_resume");
  endtask

  task automatic test_mem_qualify();
    hif.mem_en = 0; hif.misaligned_addr = 1;
    tick();
    idle_inputs();
    total++;
    if (obs16() !== ev(1, 0, 0, 3'd0)) begin
      bad++; $display("FAIL mem_unqualified: got %b want %b", obs16(), ev(1, 0, 0, 3'd0));
    end
    hif.system = 1; hif.mem_en = 1; hif.misaligned_addr = 1;
    tick();
    idle_inputs();
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(0, 1, 0, 3'd2), 16'd0}) begin
      bad++; $display("FAIL addr_over_sys: got %b want %b", {obs16(), hif.halt_cycles}, {ev(0, 1, 0, 3'd2), 16'd0});
    end
    tick();
    do_resume(3'd2, 2, "addr_resume");
  endtask

  task automatic test_resume_ignored();
    hif.dbg_resume_req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs16() !== ev(1, 0, 0, 3'd0)) begin
        bad++; $display("FAIL resume_in_run%0d: got %b want %b", k, obs16(), ev(1, 0, 0, 3'd0));
      end
    end
    idle_inputs();
  endtask

  task automatic test_random_halts();
    logic [4:0] bits;
    logic [2:0] exp;
    int d;
    for (int it = 0; it < 30; it++) begin
      bits = 5'($urandom);
      hif.misaligned_pc = bits[0]; hif.misaligned_addr = bits[1]; hif.mem_en = bits[2];
      hif.system = bits[3]; hif.dbg_halt_req = bits[4];
      exp = ref_cause(bits[0], bits[1], bits[2], bits[3], bits[4]);
      tick();
      idle_inputs();
      if (exp == 3'd0) begin
        total++;
        if ({obs16(), hif.halt_cycles} !== {ev(1, 0, 0, 3'd0), 16'(exp_cnt)}) begin
          bad++; $display("FAIL rnd_nohalt%0d: got %b want %b", it,
            {obs16(), hif.halt_cycles}, {ev(1, 0, 0, 3'd0), 16'(exp_cnt)});
        end
      end else begin
        d = $urandom_range(1, 6);
        for (int k = 0; k < d; k++) begin
          total++;
          if ({obs16(), hif.halt_cycles} !== {ev(0, 1, 0, exp), 16'(k)}) begin
            bad++; $display("FAIL rnd_halt%0d_c%0d: got %b want %b", it, k,
              {obs16(), hif.halt_cycles}, {ev(0, 1, 0, exp), 16'(k)});
          end
          set_noise();
          if (k < d - 1) tick();
        end
        do_resume(exp, d, "rnd_resume");
      end
    end
  endtask

  task automatic test_back_to_back();
    hif.system = 1;
    tick();
    idle_inputs();
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(0, 1, 0, 3'd3), 16'd0}) begin
      bad++; $display("FAIL b2b_sys: got %b want %b", {obs16(), hif.halt_cycles}, {ev(0, 1, 0, 3'd3), 16'd0});
    end
    do_resume(3'd3, 1, "b2b_resume1");
    hif.mem_en = 1; hif.misaligned_addr = 1; hif.dbg_halt_req = 1;
    tick();
    idle_inputs();
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(0, 1, 0, 3'd2), 16'd0}) begin
      bad++; $display("FAIL b2b_addr: got %b want %b", {obs16(), hif.halt_cycles}, {ev(0, 1, 0, 3'd2), 16'd0});
    end
    do_resume(3'd2, 1, "b2b_resume2");
  endtask

  task automatic test_saturation();
    sif.dbg_halt_req = 1;
    tick();
    sif.dbg_halt_req = 0;
    for (int k = 0; k < 40; k++) begin
      total++;
      if (sif.halt_cycles !== 4'((k > 15) ? 15 : k)) begin
        bad++; $display("FAIL sat_c%0d: got %0d want %0d", k, sif.halt_cycles, (k > 15) ? 15 : k);
      end
      if (k < 39) tick();
    end
    sif.dbg_resume_req = 1;
    tick();
    total++;
    if ({sif.dbg_resume_ack, sif.halt_cycles} !== 5'b11111) begin
      bad++; $display("FAIL sat_ack: got %b want %b", {sif.dbg_resume_ack, sif.halt_cycles}, 5'b11111);
    end
    sif.dbg_resume_req = 0;
    tick();
    total++;
    if ({sif.run_en, sif.halted, sif.halt_cause} !== 5'b10000) begin
      bad++; $display("FAIL sat_run: got %b want %b", {sif.run_en, sif.halted, sif.halt_cause}, 5'b10000);
    end
  endtask

  task automatic halt_by_debug();
    hif.dbg_halt_req = 1;
    tick();
    idle_inputs();
  endtask

`ifdef HALT_CTRL_STEP_EN
  task automatic test_step();
    int n;
    halt_by_debug();
    hif.dbg_step = 1; hif.step_count = 8'd0;
    tick();
    idle_inputs();
    total++;
    if (obs16() !== ev(0, 1, 0, 3'd4)) begin
      bad++; $display("FAIL step_zero: got %b want %b", obs16(), ev(0, 1, 0, 3'd4));
    end
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 3 : $urandom_range(1, 8);
      hif.dbg_step = 1; hif.step_count = 8'(n);
      tick();
      idle_inputs();
      for (int k = 0; k < n; k++) begin
        total++;
        if ({hif.run_en, hif.halted} !== 2'b10) begin
          bad++; $display("FAIL step%0d_run%0d: got %b want 10", it, k, {hif.run_en, hif.halted});
        end
        tick();
      end
      total++;
      if ({obs16(), hif.halt_cycles} !== {ev(0, 1, 0, 3'd5), 16'd0}) begin
        bad++; $display("FAIL step%0d_done: got %b want %b", it,
          {obs16(), hif.halt_cycles}, {ev(0, 1, 0, 3'd5), 16'd0});
      end
    end
    hif.dbg_step = 1; hif.step_count = 8'd3;
    tick();
    idle_inputs();
    tick();
    total++;
    if ({hif.run_en, hif.halted} !== 2'b10) begin
      bad++; $display("FAIL step_intr_run: got %b want 10", {hif.run_en, hif.halted});
    end
    hif.system = 1;
    tick();
    idle_inputs();
    total++;
    if (obs16() !== ev(0, 1, 0, 3'd3)) begin
      bad++; $display("FAIL step_intr_cause: got %b want %b", obs16(), ev(0, 1, 0, 3'd3));
    end
    hif.dbg_step = 1; hif.step_count = 8'd4;
    do_resume(3'd3, 1, "step_vs_resume");
  endtask

  task automatic test_reset_mid_step();
    halt_by_debug();
    hif.dbg_step = 1; hif.step_count = 8'd5;
    tick();
    idle_inputs();
    tick();
    #2 reset_n = 0;
    #1;
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(1, 0, 0, 3'd0), 16'd0}) begin
      bad++; $display("FAIL reset_mid_step: got %b want %b", {obs16(), hif.halt_cycles}, {ev(1, 0, 0, 3'd0), 16'd0});
    end
    tick();
    reset_n = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (obs16() !== ev(1, 0, 0, 3'd0)) begin
        bad++; $display("FAIL after_step_reset%0d: got %b want %b", k, obs16(), ev(1, 0, 0, 3'd0));
      end
    end
    exp_cnt = 0;
  endtask
`else
  task automatic test_step_disabled();
    halt_by_debug();
    hif.dbg_step = 1; hif.step_count = 8'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (obs16() !== ev(0, 1, 0, 3'd4)) begin
        bad++; $display("FAIL step_ignored%0d: got %b want %b", k, obs16(), ev(0, 1, 0, 3'd4));
      end
    end
    do_resume(3'd4, 5, "nostep_resume");
  endtask
`endif

  task automatic test_reset_mid_resume();
    hif.misaligned_pc = 1;
    tick();
    idle_inputs();
    hif.dbg_resume_req = 1;
    tick();
    total++;
    if (hif.dbg_resume_ack !== 1'b1) begin
      bad++; $display("FAIL pre_reset_ack: got %b want 1", hif.dbg_resume_ack);
    end
    #2 reset_n = 0;
    #1;
    total++;
    if ({obs16(), hif.halt_cycles} !== {ev(1, 0, 0, 3'd0), 16'd0}) begin
      bad++; $display("FAIL reset_mid_resume: got %b want %b", {obs16(), hif.halt_cycles}, {ev(1, 0, 0, 3'd0), 16'd0});
    end
    tick();
    reset_n = 1;
    hif.dbg_resume_req = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs16() !== ev(1, 0, 0, 3'd0)) begin
        bad++; $display("FAIL after_resume_reset%0d: got %b want %b", k, obs16(), ev(1, 0, 0, 3'd0));
      end
    end
    exp_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_mem_qualify();
    test_resume_ignored();
    test_random_halts();
    test_back_to_back();
    test_saturation();
`ifdef HALT_CTRL_STEP_EN
    test_step();
    test_reset_mid_step();
`else
    test_step_disabled();
`endif
    test_reset_mid_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
